// File: rtl/pipe_hazard_seq.sv
// Pipeline hazard sequencer: Moore FSM sequencing stall, flush and
// halt enables, plus a saturating count of non-RUN cycles.
module pipe_hazard_seq #(
  parameter int unsigned STACK_BUBBLES = 2,
  parameter int unsigned CNT_W         = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             hz_data,
  input  logic             hz_stack,
  input  logic             br_taken,
  input  logic             halt_req,
  input  logic             clr_cnt,
  output logic             pc_en,
  output logic             if_en,
  output logic             bubble3,
  output logic             flush12,
  output logic             busy,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [2:0] {
    RUN     = 3'd0,
    S_DATA  = 3'd1,
    S_STACK = 3'd2,
    FLUSH   = 3'd3,
    HALT    = 3'd4
  } state_t;

  localparam logic [3:0] BLOAD =
    4'(STACK_BUBBLES - 1);
  localparam logic [CNT_W-1:0] CMAX = '1;

  state_t     state, state_nx, arb;
  logic [3:0] bcnt, bcnt_nx;

  // Fixed-priority pick of the next request.
  always_comb begin
    arb = RUN;
    if (halt_req)      arb = HALT;
    else if (br_taken) arb = FLUSH;
    else if (hz_stack) arb = S_STACK;
    else if (hz_data)  arb = S_DATA;
  end

  always_comb begin
    state_nx = RUN;
    unique case (state)
      RUN, S_DATA, FLUSH: state_nx = arb;
      S_STACK: begin
        if (halt_req)       state_nx = HALT;
        else if (br_taken)  state_nx = FLUSH;
        else if (bcnt == 0) state_nx = arb;
        else                state_nx = S_STACK;
      end
      HALT: state_nx = halt_req ? HALT : RUN;
      default: state_nx = RUN;
    endcase
  end

  // Exhausted counter re-entering S_STACK is a fresh stall.
  always_comb begin
    bcnt_nx = '0;
    if (state_nx == S_STACK) begin
      if (state == S_STACK && bcnt != 0)
        bcnt_nx = bcnt - 4'd1;
      else
        bcnt_nx = BLOAD;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= RUN;
      bcnt  <= '0;
    end else begin
      state <= state_nx;
      bcnt  <= bcnt_nx;
    end
  end

  always_comb begin
    pc_en   = 1'b1;
    if_en   = 1'b1;
    bubble3 = 1'b0;
    flush12 = 1'b0;
    unique case (state)
      S_DATA, S_STACK: begin
        pc_en   = 1'b0;
        if_en   = 1'b0;
        bubble3 = 1'b1;
      end
      FLUSH: begin
        bubble3 = 1'b1;
        flush12 = 1'b1;
      end
      HALT: begin
        pc_en = 1'b0;
        if_en = 1'b0;
      end
      default: ;
    endcase
  end

  assign busy    = (state != RUN);
  assign state_o = state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      stall_cnt <= '0;
    else if (clr_cnt)
      stall_cnt <= '0;
    else if (busy && stall_cnt != CMAX)
      stall_cnt <= stall_cnt + CNT_W'(1);
  end

endmodule

// File: doc/pipe_hazard_seq.md
PIPE_HAZARD_SEQ -- requirements
Module: pipe_hazard_seq

Interface
REQ-001 The block SHALL have parameter STACK_BUBBLES, default 2, giving the bubble cycles inserted per stack hazard (legal range 1..15).
REQ-002 The block SHALL have parameter CNT_W, default 8, giving the width of stall_cnt.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset, with ports:
  clk  input  1  rising-edge clock
  reset_n  input  1  asynchronous active-low reset
REQ-004 The block SHALL have the following control ports:
  hz_data  input  1  data hazard (stall-unit H1 output), level
  hz_stack  input  1  stack hazard (PULL after PULL/PUSH in stage 3), level
  br_taken  input  1  conditional jump resolved taken in stage 3, level
  halt_req  input  1  freeze pipeline request, level
  clr_cnt  input  1  synchronous clear of stall_cnt
  pc_en  output  1  PC register update enable
  if_en  output  1  stage 1/2 register load enable
  bubble3  output  1  force NOP into stage 3 register
  flush12  output  1  clear stage 1/2 registers
  busy  output  1  any state other than RUN
  state_o  output  3  current state encoding
  stall_cnt  output  CNT_W  saturating count of non-RUN cycles

Function
REQ-005 The FSM SHALL have states RUN=0, S_DATA=1, S_STACK=2, FLUSH=3 and HALT=4; codes 5..7 SHALL return to RUN on the next edge.
REQ-006 Outputs SHALL be decoded from the registered state only (Moore), so a request sampled at edge N affects outputs after edge N.
REQ-007 Decode SHALL be:
  RUN: pc_en=1, if_en=1, bubble3=0, flush12=0
  S_DATA and S_STACK: pc_en=0, if_en=0, bubble3=1, flush12=0
  FLUSH: pc_en=1, if_en=1, bubble3=1, flush12=1
  HALT: pc_en=0, if_en=0, bubble3=0, flush12=0
REQ-008 busy SHALL be 1 whenever the state is not RUN.
REQ-009 From RUN, one request SHALL be taken per edge with fixed priority halt_req > br_taken > hz_stack > hz_data, leading to HALT, FLUSH, S_STACK or S_DATA respectively; with no request the state SHALL stay RUN.
REQ-010 S_DATA SHALL last exactly one cycle.
REQ-011 On leaving S_DATA, the next state SHALL be chosen by re-evaluating REQ-009, so a persistent hz_data keeps the pipeline stalled.
REQ-012 On entry to S_STACK, a 4-bit bubble counter SHALL load STACK_BUBBLES-1.
REQ-013 While in S_STACK, the bubble counter SHALL decrement each cycle, and the FSM SHALL exit when the counter is 0, giving exactly STACK_BUBBLES stall cycles.
REQ-014 The FSM SHALL exit S_STACK through REQ-009 evaluation.
REQ-015 br_taken arriving while in S_STACK SHALL abort the stall to FLUSH on the next edge.
REQ-016 hz_data arriving while in S_STACK SHALL be ignored.
REQ-017 FLUSH SHALL last exactly one cycle, followed by REQ-009 evaluation.
REQ-018 Requests other than halt_req SHALL be ignored during FLUSH.
REQ-019 halt_req SHALL pre-empt S_DATA, S_STACK and FLUSH on the next edge.
REQ-020 HALT SHALL persist while halt_req=1 and return to RUN on the first edge with halt_req=0.
REQ-021 A stack stall interrupted by HALT SHALL NOT resume.
REQ-022 stall_cnt SHALL increment by 1 on every edge where busy=1.
REQ-023 stall_cnt SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-024 clr_cnt=1 SHALL zero stall_cnt on that edge, with priority over increment.
REQ-025 All state SHALL be registered; no output SHALL depend combinationally on any input.

Reset
REQ-026 reset_n=0 SHALL asynchronously force state=RUN, bubble counter=0 and stall_cnt=0, giving outputs pc_en=1, if_en=1, bubble3=0, flush12=0, busy=0 and state_o=0.
REQ-027 Reset asserted mid-stall or mid-flush SHALL abandon the operation with no residual bubble.
REQ-028 Exit from reset SHALL be synchronous to the first rising clk edge after reset_n rises.

Verification
REQ-029 The bench SHALL cover each of these directed scenarios:
  Single hz_data pulse (1 cycle) in RUN -> exactly 1 cycle with pc_en=0, bubble3=1, then RUN; stall_cnt=1.
  hz_stack pulse with STACK_BUBBLES=2 -> S_STACK for 2 cycles (pc_en=0, bubble3=1), then RUN; stall_cnt=2.
  br_taken and hz_stack together in RUN -> FLUSH (flush12=1, pc_en=1) for 1 cycle, then S_STACK for 2 cycles if hz_stack is still high.
  hz_stack, then br_taken on the 1st S_STACK cycle -> FLUSH on the next edge; stall_cnt=2.
  halt_req held 5 cycles during S_STACK -> HALT for 5 cycles with all enables 0, then RUN; the stack stall does not resume.
  CNT_W=4 with hz_data held 20 cycles -> stall_cnt saturates at 15; clr_cnt=1 gives 0 on the next edge; reset_n=0 mid-stall gives RUN immediately, without waiting for a clock edge.
